// File: rtl/eth_rx_buf.sv
// Single-frame receive buffer behind the eth MAC rx byte stream: captures a frame,
// filters it on DA/FCS/length/errors and holds an accepted frame for the consumer.
module eth_rx_buf #(
    parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC = 1'b0,
    parameter int          ADDR_W  = 11,
    parameter int          MIN_LEN = 60
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_vld,
    input  logic              rx_last,
    input  logic              rx_err,
    input  logic              rx_crc_ok,
    input  logic [7:0]        rx_data,
    output logic              frame_rdy,
    output logic [ADDR_W-1:0] frame_len,
    output logic [15:0]       frame_type,
    output logic              frame_bcast,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              frame_ack,
    output logic [15:0]       ok_cnt,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] MIN_TOT  = (ADDR_W+1)'(MIN_LEN + 4);
    localparam logic [ADDR_W:0] DA_END   = (ADDR_W+1)'(6);
    localparam logic [ADDR_W:0] TYPE_HI  = (ADDR_W+1)'(12);
    localparam logic [ADDR_W:0] TYPE_LO  = (ADDR_W+1)'(13);

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [7:0]        rd_data_q;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              da_mis_q, da_mis_d;
    logic              bc_mis_q, bc_mis_d;
    logic [15:0]       type_stg_q, type_stg_d;
    logic              hold_q, hold_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [15:0]       type_q, type_d;
    logic              bcast_q, bcast_d;
    logic [15:0]       ok_q, ok_d;
    logic [15:0]       drop_q, drop_d;

    logic              we_s;
    logic [7:0]        mac_byte_s;
    logic              da_mis_now_s;
    logic              bc_mis_now_s;
    logic [15:0]       type_now_s;
    logic [ADDR_W:0]   total_s;
    logic              accept_s;

    // Expected DA byte at the current index, plus running DA/type state including this byte
    always_comb begin
        mac_byte_s = 8'h00;
        case (idx_q)
            (ADDR_W+1)'(0): mac_byte_s = MY_MAC[47:40];
            (ADDR_W+1)'(1): mac_byte_s = MY_MAC[39:32];
            (ADDR_W+1)'(2): mac_byte_s = MY_MAC[31:24];
            (ADDR_W+1)'(3): mac_byte_s = MY_MAC[23:16];
            (ADDR_W+1)'(4): mac_byte_s = MY_MAC[15:8];
            (ADDR_W+1)'(5): mac_byte_s = MY_MAC[7:0];
            default:        mac_byte_s = 8'h00;
        endcase
        // idx_q is 0 in IDLE, so the sticky flags restart with the first byte
        if (idx_q < DA_END) begin
            da_mis_now_s = ((state_q == ST_IDLE) ? 1'b0 : da_mis_q) | (rx_data != mac_byte_s);
            bc_mis_now_s = ((state_q == ST_IDLE) ? 1'b0 : bc_mis_q) | (rx_data != 8'hff);
        end else begin
            da_mis_now_s = da_mis_q;
            bc_mis_now_s = bc_mis_q;
        end
        type_now_s = type_stg_q;
        if (idx_q == TYPE_HI) begin
            type_now_s[15:8] = rx_data;
        end else if (idx_q == TYPE_LO) begin
            type_now_s[7:0] = rx_data;
        end else begin
            type_now_s = type_stg_q;
        end
        total_s  = idx_q + IDX_ONE;
        accept_s = rx_crc_ok && !rx_err && (total_s >= MIN_TOT) &&
                   (PROMISC || !da_mis_now_s || !bc_mis_now_s);
    end

    // Next-state logic for the capture FSM, hold flag, frame descriptor and counters
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        da_mis_d   = da_mis_q;
        bc_mis_d   = bc_mis_q;
        type_stg_d = type_stg_q;
        len_d      = len_q;
        type_d     = type_q;
        bcast_d    = bcast_q;
        ok_d       = ok_q;
        drop_d     = drop_q;
        we_s       = 1'b0;
        if (hold_q && frame_ack) begin
            hold_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (rx_vld) begin
                    // A single-byte frame has already ended: count it here rather than
                    // parking in DISCARD, which would swallow the following frame.
                    if (rx_last) begin
                        drop_d = drop_q + 16'd1;
                    end else if (hold_q || rx_err) begin
                        state_d = ST_DISCARD;
                    end else begin
                        state_d    = ST_RECV;
                        we_s       = 1'b1;
                        idx_d      = IDX_ONE;
                        da_mis_d   = da_mis_now_s;
                        bc_mis_d   = bc_mis_now_s;
                        type_stg_d = 16'h0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (rx_vld) begin
                    we_s       = 1'b1;
                    idx_d      = total_s;
                    da_mis_d   = da_mis_now_s;
                    bc_mis_d   = bc_mis_now_s;
                    type_stg_d = type_now_s;
                    if (rx_last) begin
                        state_d = ST_IDLE;
                        idx_d   = {(ADDR_W+1){1'b0}};
                        if (accept_s) begin
                            hold_d  = 1'b1;
                            len_d   = idx_q[ADDR_W-1:0] - ADDR_W'(3);
                            type_d  = type_now_s;
                            bcast_d = !bc_mis_now_s;
                            ok_d    = ok_q + 16'd1;
                        end else begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else if (rx_err || (idx_q == LAST_IDX)) begin
                        state_d = ST_DISCARD;
                        idx_d   = {(ADDR_W+1){1'b0}};
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DISCARD: begin
                if (rx_vld && rx_last) begin
                    state_d = ST_IDLE;
                    drop_d  = drop_q + 16'd1;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {(ADDR_W+1){1'b0}};
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= {(ADDR_W+1){1'b0}};
            da_mis_q   <= 1'b0;
            bc_mis_q   <= 1'b0;
            type_stg_q <= 16'h0000;
            hold_q     <= 1'b0;
            len_q      <= {ADDR_W{1'b0}};
            type_q     <= 16'h0000;
            bcast_q    <= 1'b0;
            ok_q       <= 16'h0000;
            drop_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            da_mis_q   <= da_mis_d;
            bc_mis_q   <= bc_mis_d;
            type_stg_q <= type_stg_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            type_q     <= type_d;
            bcast_q    <= bcast_d;
            ok_q       <= ok_d;
            drop_q     <= drop_d;
        end
    end

    // Frame RAM: rx write port, registered consumer read port
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[idx_q[ADDR_W-1:0]] <= rx_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign frame_rdy   = hold_q;
    assign frame_len   = len_q;
    assign frame_type  = type_q;
    assign frame_bcast = bcast_q;
    assign rd_data     = rd_data_q;
    assign ok_cnt      = ok_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_eth_rx_buf.sv
// Directed bench for eth_rx_buf: frames driven on the falling edge, outputs checked on the
// falling edge against hand-computed counters, lengths and stored bytes.
module tb_eth_rx_buf;

    localparam int          ADDR_W = 11;
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BC_MAC = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] OT_MAC = 48'h02_00_00_00_00_02;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rx_vld = 1'b0;
    logic              rx_last = 1'b0;
    logic              rx_err = 1'b0;
    logic              rx_crc_ok = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              frame_rdy;
    logic [ADDR_W-1:0] frame_len;
    logic [15:0]       frame_type;
    logic              frame_bcast;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic              frame_ack = 1'b0;
    logic [15:0]       ok_cnt;
    logic [15:0]       drop_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] frm  [0:2099];
    logic [7:0] held [0:2099];

    eth_rx_buf #(.MY_MAC(MY_MAC), .PROMISC(1'b0), .ADDR_W(ADDR_W), .MIN_LEN(60)) dut (
        .clk(clk), .resetn(resetn), .rx_vld(rx_vld), .rx_last(rx_last), .rx_err(rx_err),
        .rx_crc_ok(rx_crc_ok), .rx_data(rx_data), .frame_rdy(frame_rdy), .frame_len(frame_len),
        .frame_type(frame_type), .frame_bcast(frame_bcast), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_ack(frame_ack), .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame: DA, SA 02:00:00:00:00:99, type {08,seed}, payload (i+seed)
    task automatic build(input int n, input logic [47:0] da, input logic [7:0] seed);
        logic [47:0] sa;
        logic [31:0] iv;
        sa = 48'h02_00_00_00_00_99;
        for (int i = 0; i < n; i++) begin
            iv = i + 32'(seed);
            if (i < 6)       frm[i] = da[47-8*i -: 8];
            else if (i < 12) frm[i] = sa[47-8*(i-6) -: 8];
            else if (i == 12) frm[i] = 8'h08;
            else if (i == 13) frm[i] = seed;
            else             frm[i] = iv[7:0];
        end
    endtask

    // Drive n bytes; err/ack pulsed at the given index, reset at rst_at abandons the frame
    task automatic send(input int n, input logic crc, input int err_at, input int ack_at,
                        input int rst_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rx_vld = 1'b0; rx_last = 1'b0; resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                return;
            end
            rx_vld    = 1'b1;
            rx_data   = frm[i];
            rx_last   = (i == n - 1);
            rx_crc_ok = (i == n - 1) ? crc : 1'b0;
            rx_err    = (i == err_at);
            frame_ack = (i == ack_at);
        end
        @(negedge clk);
        rx_vld = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_crc_ok = 1'b0; frame_ack = 1'b0;
    endtask

    task automatic keep(input int n);
        for (int i = 0; i < n; i++) held[i] = frm[i];
    endtask

    // Pipelined reads: address on one falling edge, data checked on the next
    task automatic read_chk(input int lo, input int hi);
        rd_addr = ADDR_W'(lo);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk);
            chk_eq($sformatf("rd[%0d]", a), {24'd0, rd_data}, {24'd0, held[a]});
            rd_addr = ADDR_W'(a + 1);
        end
    endtask

    task automatic ack();
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        chk_eq("rdy_after_ack", {31'd0, frame_rdy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        chk_eq("rst_rdy", {31'd0, frame_rdy}, 32'd0);
        chk_eq("rst_len", {21'd0, frame_len}, 32'd0);
        chk_eq("rst_type", {16'd0, frame_type}, 32'd0);
        chk_eq("rst_bcast", {31'd0, frame_bcast}, 32'd0);
        chk_eq("rst_ok", {16'd0, ok_cnt}, 32'd0);
        chk_eq("rst_drop", {16'd0, drop_cnt}, 32'd0);

        // 1: unicast 60+FCS accepted
        build(64, MY_MAC, 8'h00); keep(64);
        send(64, 1'b1, -1, -1, -1);
        chk_eq("t1_rdy", {31'd0, frame_rdy}, 32'd1);
        chk_eq("t1_len", {21'd0, frame_len}, 32'd60);
        chk_eq("t1_type", {16'd0, frame_type}, 32'h0800);
        chk_eq("t1_bcast", {31'd0, frame_bcast}, 32'd0);
        chk_eq("t1_ok", {16'd0, ok_cnt}, 32'd1);
        read_chk(0, 59);
        ack();
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        chk_eq("ack_idle_rdy", {31'd0, frame_rdy}, 32'd0);

        // 2: broadcast accepted, foreign DA dropped
        build(64, BC_MAC, 8'h00); keep(64);
        send(64, 1'b1, -1, -1, -1);
        chk_eq("t2_rdy", {31'd0, frame_rdy}, 32'd1);
        chk_eq("t2_bcast", {31'd0, frame_bcast}, 32'd1);
        chk_eq("t2_ok", {16'd0, ok_cnt}, 32'd2);
        ack();
        build(64, OT_MAC, 8'h00);
        send(64, 1'b1, -1, -1, -1);
        chk_eq("t2_drop", {16'd0, drop_cnt}, 32'd1);
        chk_eq("t2_rdy0", {31'd0, frame_rdy}, 32'd0);

        // 3: bad FCS, mid-frame error, runts (36 and 59 bytes of payload)
        build(64, MY_MAC, 8'h00);
        send(64, 1'b0, -1, -1, -1);
        chk_eq("t3_crc", {16'd0, drop_cnt}, 32'd2);
        send(64, 1'b1, 20, -1, -1);
        chk_eq("t3_err", {16'd0, drop_cnt}, 32'd3);
        build(40, MY_MAC, 8'h00);
        send(40, 1'b1, -1, -1, -1);
        chk_eq("t3_runt40", {16'd0, drop_cnt}, 32'd4);
        build(63, MY_MAC, 8'h00);
        send(63, 1'b1, -1, -1, -1);
        chk_eq("t3_runt63", {16'd0, drop_cnt}, 32'd5);
        chk_eq("t3_ok", {16'd0, ok_cnt}, 32'd2);
        chk_eq("t3_rdy", {31'd0, frame_rdy}, 32'd0);

        // 4: held A blocks B; ack during B2 still drops B2; C accepted after
        build(64, MY_MAC, 8'h10); keep(64);
        send(64, 1'b1, -1, -1, -1);
        chk_eq("t4_ok_a", {16'd0, ok_cnt}, 32'd3);
        build(64, MY_MAC, 8'h80);
        send(64, 1'b1, -1, -1, -1);
        chk_eq("t4_drop_b", {16'd0, drop_cnt}, 32'd6);
        chk_eq("t4_rdy_b", {31'd0, frame_rdy}, 32'd1);
        chk_eq("t4_type_a", {16'd0, frame_type}, 32'h0810);
        read_chk(10, 25);
        send(64, 1'b1, -1, 10, -1);
        chk_eq("t4_drop_b2", {16'd0, drop_cnt}, 32'd7);
        chk_eq("t4_rdy_b2", {31'd0, frame_rdy}, 32'd0);
        build(100, MY_MAC, 8'h22); keep(100);
        send(100, 1'b1, -1, -1, -1);
        chk_eq("t4_ok_c", {16'd0, ok_cnt}, 32'd4);
        chk_eq("t4_len_c", {21'd0, frame_len}, 32'd96);
        chk_eq("t4_type_c", {16'd0, frame_type}, 32'h0822);
        read_chk(90, 95);
        ack();

        // 5: overflow (2058 bytes) dropped, then a normal frame
        build(2058, MY_MAC, 8'h33);
        send(2058, 1'b1, -1, -1, -1);
        chk_eq("t5_drop", {16'd0, drop_cnt}, 32'd8);
        chk_eq("t5_rdy0", {31'd0, frame_rdy}, 32'd0);
        build(70, MY_MAC, 8'h44); keep(70);
        send(70, 1'b1, -1, -1, -1);
        chk_eq("t5_ok", {16'd0, ok_cnt}, 32'd5);
        chk_eq("t5_len", {21'd0, frame_len}, 32'd66);
        read_chk(0, 15);
        ack();

        // 6: reset at byte 30, then a clean frame
        build(64, MY_MAC, 8'h55);
        send(64, 1'b1, -1, -1, 30);
        @(negedge clk);
        chk_eq("t6_ok0", {16'd0, ok_cnt}, 32'd0);
        chk_eq("t6_drop0", {16'd0, drop_cnt}, 32'd0);
        chk_eq("t6_rdy0", {31'd0, frame_rdy}, 32'd0);
        build(64, MY_MAC, 8'h66); keep(64);
        send(64, 1'b1, -1, -1, -1);
        chk_eq("t6_ok1", {16'd0, ok_cnt}, 32'd1);
        chk_eq("t6_drop", {16'd0, drop_cnt}, 32'd0);
        chk_eq("t6_rdy1", {31'd0, frame_rdy}, 32'd1);
        read_chk(40, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
